// File: rtl/xadac_pkg.sv
// xadac_pkg: shared xadac link types, funct3 encodings and the responder ALU
package xadac_pkg;
  localparam int SbLen = 8;
  typedef logic [31:0] InstrT;
  typedef logic [31:0] DataT;
  typedef logic [$clog2(SbLen)-1:0] IdT;
  typedef struct packed {IdT id; InstrT instr;} DecReqT;
  typedef struct packed {IdT id; logic accept; logic rd_write;} DecRspT;
  typedef struct packed {IdT id; InstrT instr; DataT rs1; DataT rs2;} ExeReqT;
  typedef struct packed {IdT id; DataT rd; logic rd_write;} ExeRspT;
  localparam logic [2:0] F3Add = 3'b000;
  localparam logic [2:0] F3Sll = 3'b001;
  localparam logic [2:0] F3Xor = 3'b100;
  localparam logic [2:0] F3Srl = 3'b101;
  localparam logic [2:0] F3Or  = 3'b110;
  localparam logic [2:0] F3And = 3'b111;
  localparam int ShW = $clog2($bits(DataT));
  function automatic DataT alu(input logic [2:0] f3, input DataT a, input DataT b);
    logic [ShW-1:0] sh;
    sh = b[ShW-1:0];
    return f3 == F3Add ? a + b :
           f3 == F3Sll ? a << sh :
           f3 == F3Xor ? a ^ b :
           f3 == F3Srl ? a >> sh :
           f3 == F3Or  ? a | b :
           f3 == F3And ? a & b : '0;
  endfunction
endpackage

// File: rtl/xadac_if.sv
// xadac_if: decode/execute request-response link between accelerator master and responder
interface xadac_if;
  logic dec_req_valid, dec_req_ready;
  xadac_pkg::DecReqT dec_req;
  logic dec_rsp_valid, dec_rsp_ready;
  xadac_pkg::DecRspT dec_rsp;
  logic exe_req_valid, exe_req_ready;
  xadac_pkg::ExeReqT exe_req;
  logic exe_rsp_valid, exe_rsp_ready;
  xadac_pkg::ExeRspT exe_rsp;
  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );
  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );
endinterface

// File: rtl/xadac_fifo.sv
// xadac_fifo: parameterised synchronous FIFO with simultaneous push/pop
module xadac_fifo #(
  parameter type T = logic,
  parameter int Depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic empty,
  output logic full,
  output logic [$clog2(Depth+1)-1:0] usage
);
  localparam int PW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int UW = $clog2(Depth+1);
  T mem [Depth];
  logic [PW-1:0] wp, rp;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(Depth-1) ? '0 : p + 1'b1;
  endfunction
  assign empty = usage == '0;
  assign full = usage == UW'(Depth);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      usage <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= inc(wp);
      end
      if (pop) rp <= inc(rp);
      usage <= usage + UW'(push) - UW'(pop);
    end
endmodule

// File: rtl/xadac_resp.sv
// xadac_resp: terminating xadac responder with pending table, ALU pipeline and credited response FIFO
module xadac_resp
  import xadac_pkg::*;
#(
  parameter InstrT Mask = 32'h0000007F,
  parameter InstrT Match = 32'h0000000B,
  parameter int Latency = 2,
  parameter int FifoDepth = 4
) (
  input  logic clk,
  input  logic rst,
  xadac_if.slv slv,
  output logic busy,
  output logic err
);
  localparam int CW = $clog2(FifoDepth+1);
  logic [SbLen-1:0] pend;
  logic [CW-1:0] cnt, usage;
  logic dec_hs, dec_acc, exe_hs, rsp_hs, hit, push, empty, full;
  ExeRspT word, din, head;
  assign slv.dec_req_ready = !slv.dec_rsp_valid || slv.dec_rsp_ready;
  assign dec_hs = slv.dec_req_valid && slv.dec_req_ready;
  assign dec_acc = (slv.dec_req.instr & Mask) == Match;
  assign slv.exe_req_ready = cnt < CW'(FifoDepth);
  assign exe_hs = slv.exe_req_valid && slv.exe_req_ready;
  assign rsp_hs = slv.exe_rsp_valid && slv.exe_rsp_ready;
  // execute samples the table before this cycle's decode update
  assign hit = pend[slv.exe_req.id];
  assign word = '{id: slv.exe_req.id,
                  rd: hit ? alu(slv.exe_req.instr[14:12], slv.exe_req.rs1, slv.exe_req.rs2) : '0,
                  rd_write: hit && slv.exe_req.instr[11:7] != 5'd0};
  assign slv.exe_rsp_valid = !empty;
  assign slv.exe_rsp = head;
  assign busy = |pend || cnt != '0 || slv.dec_rsp_valid || usage != '0;
  always_ff @(posedge clk)
    if (rst) begin
      slv.dec_rsp_valid <= 1'b0;
      slv.dec_rsp <= '0;
      pend <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      slv.dec_rsp_valid <= dec_hs || (slv.dec_rsp_valid && !slv.dec_rsp_ready);
      if (dec_hs)
        slv.dec_rsp <= '{id: slv.dec_req.id, accept: dec_acc,
                         rd_write: dec_acc && slv.dec_req.instr[11:7] != 5'd0};
      pend <= (pend & ~(SbLen'(exe_hs && hit) << slv.exe_req.id))
            | (SbLen'(dec_hs && dec_acc) << slv.dec_req.id);
      cnt <= cnt + CW'(exe_hs) - CW'(rsp_hs);
      err <= err || (exe_hs && !hit) || (dec_hs && dec_acc && pend[slv.dec_req.id])
           || (push && full && !rsp_hs);
    end
  // the FIFO write itself is the last latency stage
  if (Latency == 1) begin : g_direct
    assign push = exe_hs;
    assign din = word;
  end else begin : g_pipe
    logic [Latency-2:0] pv;
    ExeRspT pd [Latency-1];
    always_ff @(posedge clk)
      if (rst) begin
        pv <= '0;
        for (int i = 0; i < Latency-1; i++) pd[i] <= '0;
      end else begin
        pv[0] <= exe_hs;
        pd[0] <= word;
        for (int i = 1; i < Latency-1; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
      end
    assign push = pv[Latency-2];
    assign din = pd[Latency-2];
  end
  xadac_fifo #(.T(ExeRspT), .Depth(FifoDepth)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(din),
    .pop(rsp_hs),
    .dout(head),
    .empty(empty),
    .full(full),
    .usage(usage)
  );
endmodule
